// File: rtl/pc_fetch_unit.sv
// Program-counter owner and fetch sequencer: requests the word at pc, holds it
// for the core, and forms the next pc from pc_src when the core retires it.
module pc_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      pc_src,
  input  logic [XLEN-1:0] branch_target,
  input  logic [XLEN-1:0] jalr_target,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            misaligned,
  output logic [15:0]     redirect_count,
  output logic [1:0]      fsm_state
);

  // Handshakes: a request transfers on a rising edge where imem_req_valid and
  // imem_req_ready are both high; imem_rsp_valid has no ready and counts only
  // in WAIT; an instruction retires on an edge with inst_valid and inst_ready.
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [31:0]     inst_q;
  logic [XLEN-1:0] next_pc;
  logic            redirect;

  // pc_src 11 is reserved and falls back to sequential flow.
  always_comb begin
    next_pc  = pc + XLEN'(4);
    redirect = 1'b0;
    case (pc_src)
      2'b01: begin
        next_pc  = branch_target;
        redirect = 1'b1;
      end
      2'b10: begin
        next_pc  = {jalr_target[XLEN-1:1], 1'b0};
        redirect = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_REQ;
      pc             <= RESET_PC;
      inst_q         <= '0;
      misaligned     <= 1'b0;
      redirect_count <= '0;
    end else begin
      case (state)
        S_REQ: begin
          if (imem_req_ready) state <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            inst_q <= imem_rsp_data;
            state  <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (inst_ready) begin
            if (redirect && redirect_count != 16'hFFFF)
              redirect_count <= redirect_count + 16'd1;
            // A misaligned target freezes pc at the offending instruction.
            if (next_pc[1:0] == 2'b00) begin
              pc    <= next_pc;
              state <= S_REQ;
            end else begin
              misaligned <= 1'b1;
              state      <= S_HALT;
            end
          end
        end
        S_HALT: ;
        default: state <= S_HALT;
      endcase
    end
  end

  assign imem_req_valid = (state == S_REQ);
  assign imem_addr      = pc;
  assign inst_valid     = (state == S_HOLD);
  assign inst           = inst_q;
  assign inst_pc        = pc;
  assign fsm_state      = state;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: drives memory and core handshakes by hand
// and checks every fetch address against an expected queue.
module tb_pc_fetch_unit;
  localparam int          XLEN   = 32;
  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [1:0]  ST_REQ = 2'd0, ST_WAIT = 2'd1, ST_HOLD = 2'd2, ST_HALT = 2'd3;

  logic        clk;
  logic        rst_n;
  logic [1:0]  pc_src;
  logic [31:0] branch_target;
  logic [31:0] jalr_target;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        misaligned;
  logic [15:0] redirect_count;
  logic [1:0]  fsm_state;

  pc_fetch_unit #(.XLEN(XLEN), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n), .pc_src(pc_src),
    .branch_target(branch_target), .jalr_target(jalr_target),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .misaligned(misaligned), .redirect_count(redirect_count),
    .fsm_state(fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: every accepted request must match the next expected pc
  always @(negedge clk) begin
    if (rst_n && imem_req_valid && imem_req_ready) begin
      check("fetch_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("fetch_addr", imem_addr, exp_q.pop_front());
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_valid"}, 32'(imem_req_valid), 32'd1);
    check({tag, "_addr"}, imem_addr, RST_PC);
    check({tag, "_inst_valid"}, 32'(inst_valid), 32'd0);
    check({tag, "_inst"}, inst, 32'd0);
    check({tag, "_inst_pc"}, inst_pc, RST_PC);
    check({tag, "_misaligned"}, 32'(misaligned), 32'd0);
    check({tag, "_redirects"}, 32'(redirect_count), 32'd0);
    check({tag, "_state"}, 32'(fsm_state), 32'(ST_REQ));
  endtask

  // driver: one complete fetch/retire of the word at exp_pc
  task automatic fetch_one(input logic [31:0] exp_pc, input int req_dly, input int rsp_dly,
                           input int ret_dly, input bit stray, input logic [1:0] src,
                           input logic [31:0] bt, input logic [31:0] jt, input logic [31:0] word);
    check("req_valid", 32'(imem_req_valid), 32'd1);
    check("req_addr", imem_addr, exp_pc);
    check("req_state", 32'(fsm_state), 32'(ST_REQ));
    for (int i = 0; i < req_dly; i++) begin
      if (stray && i == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
      end
      step();
      imem_rsp_valid = 1'b0;
      check("req_hold_addr", imem_addr, exp_pc);
      check("req_hold_state", 32'(fsm_state), 32'(ST_REQ));
    end
    exp_q.push_back(exp_pc);
    imem_req_ready = 1'b1;
    if (stray) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hDEAD_BEEF;
    end
    step();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    check("wait_state", 32'(fsm_state), 32'(ST_WAIT));
    check("wait_req_valid", 32'(imem_req_valid), 32'd0);
    for (int i = 0; i < rsp_dly; i++) begin
      step();
      check("wait_hold_state", 32'(fsm_state), 32'(ST_WAIT));
      check("wait_hold_addr", imem_addr, exp_pc);
    end
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = word;
    step();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    check("hold_state", 32'(fsm_state), 32'(ST_HOLD));
    check("hold_inst_valid", 32'(inst_valid), 32'd1);
    check("hold_inst", inst, word);
    check("hold_inst_pc", inst_pc, exp_pc);
    for (int i = 0; i < ret_dly; i++) begin
      if (stray && i == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
      end
      step();
      imem_rsp_valid = 1'b0;
      check("hold_stable_inst", inst, word);
      check("hold_stable_pc", inst_pc, exp_pc);
      check("hold_stable_state", 32'(fsm_state), 32'(ST_HOLD));
    end
    inst_ready    = 1'b1;
    pc_src        = src;
    branch_target = bt;
    jalr_target   = jt;
    step();
    inst_ready    = 1'b0;
    pc_src        = 2'b00;
    branch_target = '0;
    jalr_target   = '0;
  endtask

  initial begin
    rst_n = 1'b0; pc_src = 2'b00; branch_target = '0; jalr_target = '0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0; inst_ready = 1'b0;
    step();
    step();
    check_reset_outputs("rst");
    imem_req_ready = 1'b0;
    rst_n = 1'b1;

    // sequential, branch, jalr (bit 0 cleared)
    fetch_one(32'h100, 0, 0, 0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0000_0013);
    fetch_one(32'h104, 0, 0, 0, 1'b0, 2'b01, 32'h200, 32'h0000_DEAD, 32'h1111_1111);
    check("redirects_1", 32'(redirect_count), 32'd1);
    fetch_one(32'h200, 0, 0, 0, 1'b0, 2'b10, 32'h400, 32'h301, 32'h2222_2222);
    check("redirects_2", 32'(redirect_count), 32'd2);

    // backpressure on every handshake
    fetch_one(32'h300, 5, 4, 3, 1'b0, 2'b00, 32'h0, 32'h0, 32'h3333_3333);

    // stray responses in REQ, during the handshake and in HOLD; reserved pc_src
    fetch_one(32'h304, 1, 0, 1, 1'b1, 2'b11, 32'h500, 32'h600, 32'h4444_4444);
    check("redirects_reserved", 32'(redirect_count), 32'd2);

    // wrap at the top of the address space
    fetch_one(32'h308, 0, 0, 0, 1'b0, 2'b01, 32'hFFFF_FFFC, 32'h0, 32'h5555_5555);
    fetch_one(32'hFFFF_FFFC, 0, 0, 0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h6666_6666);
    check("wrap_addr", imem_addr, 32'h0);
    check("wrap_no_flag", 32'(misaligned), 32'd0);
    check("redirects_3", 32'(redirect_count), 32'd3);

    // misaligned branch target halts with pc frozen
    fetch_one(32'h0, 0, 0, 0, 1'b0, 2'b01, 32'h202, 32'h0, 32'h7777_7777);
    imem_req_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hDEAD_BEEF;
      step();
      check("halt_state", 32'(fsm_state), 32'(ST_HALT));
      check("halt_misaligned", 32'(misaligned), 32'd1);
      check("halt_req_valid", 32'(imem_req_valid), 32'd0);
      check("halt_inst_valid", 32'(inst_valid), 32'd0);
      check("halt_pc", imem_addr, 32'h0);
      check("halt_redirects", 32'(redirect_count), 32'd4);
    end
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;

    // reset out of HALT
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_halt");
    step();
    rst_n = 1'b1;

    // reset while a response is outstanding
    exp_q.push_back(RST_PC);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    check("midwait_state", 32'(fsm_state), 32'(ST_WAIT));
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_wait");
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    step();
    rst_n = 1'b1;
    step();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    check("stale_rsp_state", 32'(fsm_state), 32'(ST_REQ));
    check("stale_rsp_inst", inst, 32'd0);
    fetch_one(RST_PC, 0, 0, 0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h8888_8888);
    check("post_reset_next", imem_addr, 32'h104);

    check("fetch_q_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
